// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the mem_arbiter block: FSM state encodings,
// grant_id codes and the default bus widths.
package mem_arbiter_pkg;

  localparam int ADDR_L_DEF = 32;
  localparam int DATA_L_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GID_NONE = 2'd0,
    GID_IF   = 2'd1,
    GID_DMR  = 2'd2,
    GID_DMW  = 2'd3
  } gid_e;

  function automatic logic gid_is_read(input gid_e g);
    return (g == GID_IF) || (g == GID_DMR);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/DM requesters, mem_arbiter and mem_ctrl.
// master = the arbiter's view, slave = the surrounding requesters and mem_ctrl.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_L = ADDR_L_DEF,
  parameter int DATA_L = DATA_L_DEF
);

  logic              if_re;
  logic [ADDR_L-1:0] if_addr;
  logic [DATA_L-1:0] if_rdata;
  logic              if_rack;

  logic              dm_re;
  logic              dm_we;
  logic [ADDR_L-1:0] dm_addr;
  logic [DATA_L-1:0] dm_wdata;
  logic [DATA_L-1:0] dm_rdata;
  logic              dm_rack;
  logic              dm_wack;

  logic [ADDR_L-1:0] mc_raddr;
  logic [ADDR_L-1:0] mc_waddr;
  logic [DATA_L-1:0] mc_dout;
  logic [DATA_L-1:0] mc_din;
  logic              mc_re;
  logic              mc_we;
  logic              mc_rack;
  logic              mc_wack;

  logic              busy;
  logic [1:0]        grant_id;

  modport master (
    input  if_re, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mc_din, mc_rack, mc_wack,
    output if_rdata, if_rack, dm_rdata, dm_rack, dm_wack,
           mc_raddr, mc_waddr, mc_dout, mc_re, mc_we, busy, grant_id
  );

  modport slave (
    output if_re, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mc_din, mc_rack, mc_wack,
    input  if_rdata, if_rack, dm_rdata, dm_rack, dm_wack,
           mc_raddr, mc_waddr, mc_dout, mc_re, mc_we, busy, grant_id
  );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner select for mem_arbiter. With ARB_RR_EN defined, IF and DM
// alternate on contention; otherwise fixed priority DM write > DM read > IF.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic if_re,
  input  logic dm_re,
  input  logic dm_we,
`ifdef ARB_RR_EN
  input  logic rr_dm,
`endif
  output gid_e gid
);

  logic dm_req;
  logic dm_wins;

  always_comb begin
    dm_req = dm_re | dm_we;
`ifdef ARB_RR_EN
    // rr_dm set means DM was not the last one served, so it wins a tie
    dm_wins = dm_req && (!if_re || rr_dm);
`else
    dm_wins = dm_req;
`endif
    if (dm_wins) begin
      gid = dm_we ? GID_DMW : GID_DMR;
    end else if (if_re) begin
      gid = GID_IF;
    end else begin
      gid = GID_NONE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single mem_ctrl CPU-side port between instruction fetch and data
// memory, one transaction at a time. Optional macro ARB_RR_EN selects round robin.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_L = ADDR_L_DEF,
  parameter int DATA_L = DATA_L_DEF
)
(
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master bus
);

  state_e            state_q,    state_d;
  gid_e              gid_q,      gid_d;
  logic [ADDR_L-1:0] addr_q,     addr_d;
  logic [DATA_L-1:0] wdata_q,    wdata_d;
  logic              mc_re_q,    mc_re_d;
  logic              mc_we_q,    mc_we_d;
  logic [DATA_L-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_L-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_rack_q,  if_rack_d;
  logic              dm_rack_q,  dm_rack_d;
  logic              dm_wack_q,  dm_wack_d;
  gid_e              pick;

`ifdef ARB_RR_EN
  logic              rr_dm_q,    rr_dm_d;

  arb_pick u_pick (
    .if_re (bus.if_re),
    .dm_re (bus.dm_re),
    .dm_we (bus.dm_we),
    .rr_dm (rr_dm_q),
    .gid   (pick)
  );
`else
  arb_pick u_pick (
    .if_re (bus.if_re),
    .dm_re (bus.dm_re),
    .dm_we (bus.dm_we),
    .gid   (pick)
  );
`endif

  always_comb begin
    state_d    = state_q;
    gid_d      = gid_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mc_re_d    = mc_re_q;
    mc_we_d    = mc_we_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_rack_d  = 1'b0;
    dm_rack_d  = 1'b0;
    dm_wack_d  = 1'b0;
`ifdef ARB_RR_EN
    rr_dm_d    = rr_dm_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick != GID_NONE) begin
          state_d = ST_GNT;
          gid_d   = pick;
          addr_d  = (pick == GID_IF) ? bus.if_addr : bus.dm_addr;
          wdata_d = bus.dm_wdata;
          mc_re_d = gid_is_read(pick);
          mc_we_d = (pick == GID_DMW);
`ifdef ARB_RR_EN
          rr_dm_d = (pick == GID_IF);
`endif
        end
      end
      ST_GNT: begin
        // only the ack matching the granted direction ends the transaction
        if (gid_is_read(gid_q) && bus.mc_rack) begin
          mc_re_d = 1'b0;
          state_d = ST_DONE;
          gid_d   = GID_NONE;
          if (gid_q == GID_IF) begin
            if_rdata_d = bus.mc_din;
            if_rack_d  = 1'b1;
          end else begin
            dm_rdata_d = bus.mc_din;
            dm_rack_d  = 1'b1;
          end
        end else if ((gid_q == GID_DMW) && bus.mc_wack) begin
          mc_we_d   = 1'b0;
          state_d   = ST_DONE;
          gid_d     = GID_NONE;
          dm_wack_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      gid_q      <= GID_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      mc_re_q    <= 1'b0;
      mc_we_q    <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_rack_q  <= 1'b0;
      dm_rack_q  <= 1'b0;
      dm_wack_q  <= 1'b0;
`ifdef ARB_RR_EN
      rr_dm_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gid_q      <= gid_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mc_re_q    <= mc_re_d;
      mc_we_q    <= mc_we_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_rack_q  <= if_rack_d;
      dm_rack_q  <= dm_rack_d;
      dm_wack_q  <= dm_wack_d;
`ifdef ARB_RR_EN
      rr_dm_q    <= rr_dm_d;
`endif
    end
  end

  assign bus.mc_raddr = addr_q;
  assign bus.mc_waddr = addr_q;
  assign bus.mc_dout  = wdata_q;
  assign bus.mc_re    = mc_re_q;
  assign bus.mc_we    = mc_we_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.dm_rdata = dm_rdata_q;
  assign bus.if_rack  = if_rack_q;
  assign bus.dm_rack  = dm_rack_q;
  assign bus.dm_wack  = dm_wack_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.grant_id = gid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cycle checks plus a scoreboard of
// expected requester acks. Expectations follow ARB_RR_EN when it is defined.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_L(32), .DATA_L(8)) bus ();

  mem_arbiter #(.ADDR_L(32), .DATA_L(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0] gid;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester ack monitor: every ack pulse must match the oldest expectation
  always @(negedge clk) begin : sb_mon
    exp_t       e;
    logic [1:0] k;
    logic [7:0] d;
    if (rst && (bus.if_rack || bus.dm_rack || bus.dm_wack)) begin
      if (sb.size() > 0) e = sb.pop_front();
      else e = '0;
      k = bus.if_rack ? 2'd1 : (bus.dm_rack ? 2'd2 : 2'd3);
      d = (k == 2'd1) ? bus.if_rdata : ((k == 2'd2) ? bus.dm_rdata : 8'h00);
      check_eq("ack_onehot", $countones({bus.if_rack, bus.dm_rack, bus.dm_wack}), 1);
      check_eq("sb_kind", k, e.gid);
      check_eq("sb_data", d, e.data);
    end
  end

  // Plays mem_ctrl for one transaction; optionally drops the served request in DONE
  task automatic serve(input int dly, input logic [7:0] d, input logic [1:0] exp_gid,
                       input logic [31:0] exp_addr, input bit drop);
    int n;
    n = 0;
    while (!(bus.mc_re || bus.mc_we) && n < 16) begin
      tick();
      n++;
    end
    check_eq("serve_gid", bus.grant_id, exp_gid);
    if (bus.mc_re || bus.mc_we) begin
      check_eq("serve_addr", (exp_gid == 2'd3) ? bus.mc_waddr : bus.mc_raddr, exp_addr);
      repeat (dly) tick();
      bus.mc_din = d;
      if (exp_gid == 2'd3) bus.mc_wack = 1'b1;
      else bus.mc_rack = 1'b1;
      sb.push_back(exp_t'{exp_gid, (exp_gid == 2'd3) ? 8'h00 : d});
      tick();
      bus.mc_rack = 1'b0;
      bus.mc_wack = 1'b0;
      if (drop) begin
        if (exp_gid == 2'd1) bus.if_re = 1'b0;
        else begin
          bus.dm_re = 1'b0;
          bus.dm_we = 1'b0;
        end
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.if_re = 1'b0; bus.if_addr = '0;
    bus.dm_re = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mc_din = '0; bus.mc_rack = 1'b0; bus.mc_wack = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_mc_re", bus.mc_re, 0);
    check_eq("rst_mc_we", bus.mc_we, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_gid", bus.grant_id, 0);
    check_eq("rst_if_rdata", bus.if_rdata, 0);
    rst = 1'b1;
    tick();

    // IF read, mem_ctrl acks in cycle 3
    bus.if_re = 1'b1; bus.if_addr = 32'h100;
    tick();
    check_eq("t1_c1_mc_re", bus.mc_re, 1);
    check_eq("t1_c1_raddr", bus.mc_raddr, 32'h100);
    check_eq("t1_c1_gid", bus.grant_id, 1);
    check_eq("t1_c1_busy", bus.busy, 1);
    tick();
    check_eq("t1_c2_mc_re", bus.mc_re, 1);
    check_eq("t1_c2_rack", bus.if_rack, 0);
    tick();
    check_eq("t1_c3_mc_re", bus.mc_re, 1);
    check_eq("t1_c3_rack", bus.if_rack, 0);
    bus.mc_din = 8'hAB; bus.mc_rack = 1'b1;
    sb.push_back(exp_t'{2'd1, 8'hAB});
    tick();
    check_eq("t1_c4_rack", bus.if_rack, 1);
    check_eq("t1_c4_rdata", bus.if_rdata, 8'hAB);
    check_eq("t1_c4_mc_re", bus.mc_re, 0);
    bus.mc_rack = 1'b0; bus.mc_din = 8'h00; bus.if_re = 1'b0;
    tick();
    check_eq("t1_c5_rack", bus.if_rack, 0);
    check_eq("t1_c5_busy", bus.busy, 0);

    // DM write, mem_ctrl acks in cycle 1
    bus.dm_we = 1'b1; bus.dm_addr = 32'h40; bus.dm_wdata = 8'h5A;
    tick();
    check_eq("t2_c1_mc_we", bus.mc_we, 1);
    check_eq("t2_c1_mc_re", bus.mc_re, 0);
    check_eq("t2_c1_waddr", bus.mc_waddr, 32'h40);
    check_eq("t2_c1_dout", bus.mc_dout, 8'h5A);
    bus.mc_wack = 1'b1;
    sb.push_back(exp_t'{2'd3, 8'h00});
    tick();
    check_eq("t2_c2_wack", bus.dm_wack, 1);
    check_eq("t2_c2_mc_we", bus.mc_we, 0);
    bus.mc_wack = 1'b0; bus.dm_we = 1'b0;
    tick();
    check_eq("t2_c3_wack", bus.dm_wack, 0);
    check_eq("hold_if_rdata", bus.if_rdata, 8'hAB);

    // Spurious write ack during an IF read grant
    bus.if_re = 1'b1; bus.if_addr = 32'h300;
    tick();
    bus.mc_wack = 1'b1;
    tick();
    bus.mc_wack = 1'b0;
    check_eq("t5_busy", bus.busy, 1);
    check_eq("t5_gid", bus.grant_id, 1);
    check_eq("t5_mc_re", bus.mc_re, 1);
    check_eq("t5_rack", bus.if_rack, 0);
    serve(1, 8'h3C, 2'd1, 32'h300, 1'b1);

    // dm_re and dm_we together are a write
    bus.dm_re = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h80; bus.dm_wdata = 8'h77;
    tick();
    check_eq("t4_gid", bus.grant_id, 3);
    check_eq("t4_mc_we", bus.mc_we, 1);
    check_eq("t4_mc_re", bus.mc_re, 0);
    check_eq("t4_dout", bus.mc_dout, 8'h77);
    serve(0, 8'h00, 2'd3, 32'h80, 1'b1);
    check_eq("hold_dm_rdata", bus.dm_rdata, 8'h00);

    // Asynchronous reset in the middle of a grant
    bus.if_re = 1'b1; bus.if_addr = 32'h500;
    tick();
    check_eq("t6_pre_mc_re", bus.mc_re, 1);
    #2 rst = 1'b0;
    #1;
    check_eq("t6_rst_mc_re", bus.mc_re, 0);
    check_eq("t6_rst_busy", bus.busy, 0);
    check_eq("t6_rst_gid", bus.grant_id, 0);
    check_eq("t6_rst_raddr", bus.mc_raddr, 0);
    check_eq("t6_rst_rdata", bus.if_rdata, 0);
    rst = 1'b1;
    tick();
    check_eq("t6_regrant", bus.mc_re, 1);
    serve(0, 8'h5E, 2'd1, 32'h500, 1'b1);

    // Simultaneous IF and DM reads, from a fresh reset
    rst = 1'b0;
    #1 rst = 1'b1;
    tick();
    bus.if_re = 1'b1; bus.if_addr = 32'h104;
    bus.dm_re = 1'b1; bus.dm_addr = 32'h200;
`ifdef ARB_RR_EN
    serve(0, 8'h11, 2'd1, 32'h104, 1'b0);
    serve(0, 8'h22, 2'd2, 32'h200, 1'b0);
    serve(0, 8'h33, 2'd1, 32'h104, 1'b0);
    bus.if_re = 1'b0; bus.dm_re = 1'b0;
    tick();
`else
    serve(0, 8'h11, 2'd2, 32'h200, 1'b1);
    serve(0, 8'h22, 2'd1, 32'h104, 1'b1);
`endif
    tick();
    check_eq("t3_idle_busy", bus.busy, 0);
    check_eq("sb_leftover", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
